// File: rtl/arith_seq_pkg.sv
// Shared definitions for the iterative arithmetic blocks: FSM state type,
// counter sizing, and two's-complement magnitude helpers on a 64-bit carrier.
package arith_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Operand helpers work on a fixed carrier; callers size-cast the result.
  localparam int MAX_W = 64;

  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic logic [MAX_W-1:0] negate(input logic [MAX_W-1:0] x);
    return ~x + MAX_W'(1);
  endfunction

  function automatic logic [MAX_W-1:0] abs_val(input logic signed [MAX_W-1:0] x);
    return x[MAX_W-1] ? negate(x) : x;
  endfunction

endpackage

// File: rtl/seq_mul_acc_add.sv
// Accumulate-step adder for the iterative multiplier; the carry out is
// dropped because the running sum never exceeds W bits.
module seq_mul_acc_add #(
  parameter int W = 16
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] sum
);

  assign sum = x + y;

endmodule

// File: rtl/seq_arr_mul.sv
// Iterative N x N shift-add multiplier with valid/ready handshake and a
// per-transaction unsigned/signed mode. Supported operand width: 2..32.
module seq_arr_mul
  import arith_seq_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           sgn,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out
);

  localparam int W2 = 2 * N;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t state, state_nxt;

  logic [W2-1:0]  acc;
  logic [W2-1:0]  mcand;
  logic [N-1:0]   mplier;
  logic [CW-1:0]  cnt;
  logic           neg;
  logic           fix;

  logic signed [MAX_W-1:0] a_ext, b_ext;
  logic [W2-1:0]  addend, sum, prod;
  logic           accept;

  // Sign-extend only in signed mode so abs_val returns raw values otherwise.
  always_comb begin
    a_ext = sgn ? MAX_W'($signed(a)) : MAX_W'(a);
    b_ext = sgn ? MAX_W'($signed(b)) : MAX_W'(b);
  end

  assign accept = (state == IDLE) && in_valid;
  assign addend = mplier[0] ? mcand : '0;
  assign prod   = neg ? W2'(negate(MAX_W'(acc))) : acc;

  seq_mul_acc_add #(.W(W2)) u_add (
    .x  (acc),
    .y  (addend),
    .sum(sum)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (fix)       state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Multiplicand shifts left and multiplier right each step, so step i sees
  // magnitude bit i and magnitude << i without a variable shifter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      fix    <= 1'b0;
      out    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        mcand  <= {{N{1'b0}}, N'(abs_val(a_ext))};
        mplier <= N'(abs_val(b_ext));
        neg    <= sgn & (a[N-1] ^ b[N-1]);
        acc    <= '0;
        cnt    <= '0;
        fix    <= 1'b0;
      end else if (state == RUN) begin
        if (!fix) begin
          acc    <= sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          // Counter parks at N-1; the extra edge is the sign fix-up.
          if (cnt == LAST) fix <= 1'b1;
          else             cnt <= cnt + CW'(1);
        end else begin
          out <= prod;
          fix <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_arr_mul.sv
// Scoreboard bench for seq_arr_mul: directed cases on an N=8 instance, then a
// randomized sweep on N=8 and N=5 instances checked against integer products.
module tb_seq_arr_mul;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clk_en = 1'b0;
  int   cmp = 0;
  int   bad = 0;

  logic        iv8 = 1'b0, s8 = 1'b0, or8 = 1'b1;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        ir8, ov8;
  logic [15:0] out8;

  logic        iv5 = 1'b0, s5 = 1'b0, or5 = 1'b1;
  logic [4:0]  a5 = '0, b5 = '0;
  logic        ir5, ov5;
  logic [9:0]  out5;

  logic [15:0] q8[$];
  logic [9:0]  q5[$];
  int acc8 = 0, prod8 = 0, acc5 = 0, prod5 = 0;
  logic rnd_on = 1'b0;

  seq_arr_mul #(.N(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .sgn(s8), .out_valid(ov8), .out_ready(or8), .out(out8)
  );

  seq_arr_mul #(.N(5)) u5 (
    .clk(clk), .rst(rst), .in_valid(iv5), .in_ready(ir5), .a(a5), .b(b5),
    .sgn(s5), .out_valid(ov5), .out_ready(or5), .out(out5)
  );

  initial begin
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference product: interpret operands as integers, multiply, wrap to 2n bits.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic s, input int n);
    longint sa, sb, m, p;
    m  = (longint'(1) << n) - 1;
    sa = longint'(a) & m;
    sb = longint'(b) & m;
    if (s && a[n-1]) sa = sa - (longint'(1) << n);
    if (s && b[n-1]) sb = sb - (longint'(1) << n);
    p = sa * sb;
    return 64'(p) & ((64'd1 << (2 * n)) - 64'd1);
  endfunction

  always @(negedge clk) begin
    if (!rst && ov8 && or8) begin
      prod8++;
      if (q8.size() == 0) begin
        cmp++; bad++;
        $display("FAIL unexpected8: got product %0h want no output", out8);
      end else check("prod8", 64'(out8), 64'(q8.pop_front()));
    end
    if (!rst && ov5 && or5) begin
      prod5++;
      if (q5.size() == 0) begin
        cmp++; bad++;
        $display("FAIL unexpected5: got product %0h want no output", out5);
      end else check("prod5", 64'(out5), 64'(q5.pop_front()));
    end
  end

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic push, input logic [15:0] exp);
    int t = 0;
    a8 = a; b8 = b; s8 = s; iv8 = 1'b1;
    @(negedge clk);
    while (!ir8 && t < 200) begin t++; @(negedge clk); end
    if (!ir8) begin
      cmp++; bad++;
      $display("FAIL accept8_timeout: got in_ready 0 want 1");
    end else if (push) begin
      q8.push_back(exp);
      acc8++;
    end
    @(posedge clk); #1 iv8 = 1'b0;
  endtask

  task automatic send5(input logic [4:0] a, input logic [4:0] b, input logic s,
                       input logic [9:0] exp);
    int t = 0;
    a5 = a; b5 = b; s5 = s; iv5 = 1'b1;
    @(negedge clk);
    while (!ir5 && t < 200) begin t++; @(negedge clk); end
    if (!ir5) begin
      cmp++; bad++;
      $display("FAIL accept5_timeout: got in_ready 0 want 1");
    end else begin
      q5.push_back(exp);
      acc5++;
    end
    @(posedge clk); #1 iv5 = 1'b0;
  endtask

  // Called right after the accepting edge; counts edges until out_valid.
  task automatic wait_ov8(output int cycles);
    cycles = 0;
    while (!ov8 && cycles < 100) begin
      @(posedge clk); cycles++; #1;
    end
  endtask

  logic [7:0]  da[5] = '{8'd138, 8'd255, 8'h8A, 8'h80, 8'h80};
  logic [7:0]  db[5] = '{8'd22,  8'd255, 8'd22, 8'h80, 8'h01};
  logic        ds[5] = '{1'b0,   1'b0,   1'b1,  1'b1,  1'b1};
  logic [15:0] dp[5] = '{16'h0BDC, 16'hFE01, 16'hF5DC, 16'h4000, 16'hFF80};

  initial begin
    int lat;
    int p0;
    logic [15:0] cap;

    // Asynchronous reset with the clock not yet running.
    #5 rst = 1'b1;
    #1;
    check("rst_in_ready",  64'(ir8), 64'd1);
    check("rst_out_valid", 64'(ov8), 64'd0);
    check("rst_out",       64'(out8), 64'd0);
    check("rst_out5",      64'(out5), 64'd0);
    #4 rst = 1'b0;
    clk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) begin
      send8(da[i], db[i], ds[i], 1'b1, dp[i]);
      wait_ov8(lat);
      check("latency8", 64'(lat), 64'd9);
      repeat (2) @(posedge clk);
      #1;
    end

    // Backpressure: product held, busy, stray in_valid ignored.
    or8 = 1'b0;
    send8(8'h7F, 8'h03, 1'b1, 1'b1, 16'(ref_mul(32'h7F, 32'h03, 1'b1, 8)));
    wait_ov8(lat);
    cap = out8;
    check("bp_value", 64'(cap), 64'h017D);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 64'(ov8), 64'd1);
      check("bp_out_hold",  64'(out8), 64'(cap));
      check("bp_in_ready",  64'(ir8), 64'd0);
      #1 a8 = 8'(i + 9); b8 = 8'd7; s8 = 1'b0; iv8 = (i % 2 == 0);
    end
    @(posedge clk); #1 iv8 = 1'b0; or8 = 1'b1;
    @(posedge clk); #1;
    check("bp_release_idle", 64'(ir8), 64'd1);
    check("bp_release_ov",   64'(ov8), 64'd0);
    check("idle_out_hold",   64'(out8), 64'(cap));
    repeat (2) @(posedge clk);
    #1;

    // Abort mid-RUN, then a clean transaction.
    send8(8'd200, 8'd100, 1'b0, 1'b0, 16'd0);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_in_ready",  64'(ir8), 64'd1);
    check("abort_out_valid", 64'(ov8), 64'd0);
    check("abort_out",       64'(out8), 64'd0);
    #1 rst = 1'b0;
    p0 = prod8;
    send8(8'd3, 8'd5, 1'b0, 1'b1, 16'd15);
    repeat (40) @(posedge clk);
    #1;
    check("abort_one_output", 64'(prod8 - p0), 64'd1);

    // Randomized sweep on both widths with random consumer stalls.
    rnd_on = 1'b1;
    fork
      while (rnd_on) begin @(posedge clk); #1 or8 = ($urandom_range(0, 3) != 0); end
      while (rnd_on) begin @(posedge clk); #1 or5 = ($urandom_range(0, 3) != 0); end
    join_none
    fork
      for (int i = 0; i < 1000; i++) begin
        logic [7:0] ra, rb; logic rs;
        ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
        repeat ($urandom_range(0, 1)) @(posedge clk);
        send8(ra, rb, rs, 1'b1, 16'(ref_mul(32'(ra), 32'(rb), rs, 8)));
      end
      for (int i = 0; i < 1000; i++) begin
        logic [4:0] ra, rb; logic rs;
        ra = 5'($urandom); rb = 5'($urandom); rs = 1'($urandom);
        repeat ($urandom_range(0, 1)) @(posedge clk);
        send5(ra, rb, rs, 10'(ref_mul(32'(ra), 32'(rb), rs, 5)));
      end
    join
    for (int t = 0; t < 500 && (q8.size() != 0 || q5.size() != 0); t++) @(posedge clk);
    rnd_on = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("drain_q8",     64'(q8.size()), 64'd0);
    check("drain_q5",     64'(q5.size()), 64'd0);
    check("count8",       64'(prod8), 64'(acc8));
    check("count5",       64'(prod5), 64'(acc5));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
